// File: rtl/instr_mem_encoder.sv
// Packs decoder-format instruction fields into 32-bit words, buffers them in a
// small FIFO and streams them into instruction memory from a start address.
module instr_mem_encoder #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [3:0]        in_cond,
  input  logic [1:0]        in_op,
  input  logic [5:0]        in_funct,
  input  logic [3:0]        in_rn,
  input  logic [3:0]        in_rd,
  input  logic [23:0]       in_operand,
  input  logic              imem_busy,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              err,
  output logic              done,
  output logic [15:0]       word_count
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state_reg, state_next;
  logic [31:0]       fifo_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]    count_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [15:0]       word_count_reg;
  logic              err_reg;

  logic              fifo_full, fifo_empty;
  logic              accept, illegal, push, pop, session_start;
  logic [31:0]       encoded;

  assign fifo_full     = (count_reg == (PTR_W+1)'(DEPTH));
  assign fifo_empty    = (count_reg == '0);
  assign in_ready      = (state_reg == RUN) && !fifo_full;
  assign accept        = in_valid && in_ready;
  assign session_start = (state_reg == IDLE) && start;

  // Data-processing/memory ops only carry a 12-bit Src2; op 11 is unused.
  assign illegal = (in_op == 2'b11) ||
                   (!in_op[1] && (in_operand[23:12] != 12'h000));
  assign push    = accept && !illegal;
  assign pop     = !fifo_empty && !imem_busy;

  always_comb begin
    encoded = {in_cond, in_op, in_funct, in_rn, in_rd, in_operand[11:0]};
    if (in_op == 2'b10) begin
      encoded = {in_cond, 2'b10, in_funct[5:4], in_operand};
    end
  end

  assign imem_we    = pop;
  assign imem_addr  = addr_reg;
  assign imem_wdata = fifo_mem[rd_ptr_reg];
  assign err        = err_reg;
  assign done       = (state_reg == DONE);
  assign word_count = word_count_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (accept && in_last) state_next = DRAIN;
      DRAIN:   if (fifo_empty) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      addr_reg       <= '0;
      word_count_reg <= '0;
      err_reg        <= 1'b0;
    end else begin
      state_reg <= state_next;
      err_reg   <= accept && illegal;
      if (session_start) begin
        addr_reg       <= start_addr;
        word_count_reg <= '0;
        wr_ptr_reg     <= '0;
        rd_ptr_reg     <= '0;
        count_reg      <= '0;
      end else begin
        if (pop) begin
          rd_ptr_reg     <= rd_ptr_reg + 1'b1;
          addr_reg       <= addr_reg + ADDR_W'(4);
          word_count_reg <= word_count_reg + 16'd1;
        end
        if (push) begin
          wr_ptr_reg <= wr_ptr_reg + 1'b1;
        end
        case ({push, pop})
          2'b10:   count_reg <= count_reg + 1'b1;
          2'b01:   count_reg <= count_reg - 1'b1;
          default: count_reg <= count_reg;
        endcase
      end
    end
  end

  // Storage needs no reset: occupancy is tracked by count_reg alone.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= encoded;
    end
  end

endmodule

// File: tb/tb_instr_mem_encoder.sv
// Directed bench for instr_mem_encoder: encoding, back-pressure, illegal
// bundles, address wrap (8-bit instance) and reset during drain.
module tb_instr_mem_encoder;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_last, imem_busy;
  logic [31:0] start_addr;
  logic [3:0]  in_cond, in_rn, in_rd;
  logic [1:0]  in_op;
  logic [5:0]  in_funct;
  logic [23:0] in_operand;

  logic        in_ready, imem_we, err, done;
  logic [31:0] imem_addr, imem_wdata;
  logic [15:0] word_count;

  logic        in_ready8, imem_we8, err8, done8;
  logic [7:0]  imem_addr8;
  logic [31:0] imem_wdata8;
  logic [15:0] word_count8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_mem_encoder #(.DEPTH(4), .ADDR_W(32)) u_dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_cond(in_cond), .in_op(in_op), .in_funct(in_funct), .in_rn(in_rn),
    .in_rd(in_rd), .in_operand(in_operand), .imem_busy(imem_busy),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .err(err), .done(done), .word_count(word_count)
  );

  instr_mem_encoder #(.DEPTH(4), .ADDR_W(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr[7:0]),
    .in_valid(in_valid), .in_ready(in_ready8), .in_last(in_last),
    .in_cond(in_cond), .in_op(in_op), .in_funct(in_funct), .in_rn(in_rn),
    .in_rd(in_rd), .in_operand(in_operand), .imem_busy(imem_busy),
    .imem_we(imem_we8), .imem_addr(imem_addr8), .imem_wdata(imem_wdata8),
    .err(err8), .done(done8), .word_count(word_count8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_session(input logic [31:0] a);
    start      = 1'b1;
    start_addr = a;
    tick();
    start = 1'b0;
  endtask

  task automatic set_fields(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                            input logic [3:0] rn, input logic [3:0] rd,
                            input logic [23:0] opd, input logic last);
    in_cond = c; in_op = o; in_funct = f; in_rn = rn; in_rd = rd;
    in_operand = opd; in_last = last;
  endtask

  // Offers one bundle and returns just after the accepting edge.
  task automatic send(input string tag, input logic [3:0] c, input logic [1:0] o,
                      input logic [5:0] f, input logic [3:0] rn, input logic [3:0] rd,
                      input logic [23:0] opd, input logic last);
    logic ok;
    set_fields(c, o, f, rn, rd, opd, last);
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = in_ready;
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk({tag, "_accepted"}, 32'(ok), 32'd1);
  endtask

  logic [31:0] exp_busy [5] = '{32'hE0000001, 32'hE0001002, 32'hE0002003,
                                32'hE0003004, 32'hE0004005};

  initial begin
    int  k;
    logic acc;
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int   k;
    logic acc;
    reset = 1'b1; start = 1'b0; start_addr = '0; in_valid = 1'b0; imem_busy = 1'b0;
    set_fields(4'h0, 2'b00, 6'h00, 4'h0, 4'h0, 24'h0, 1'b0);
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_we", 32'(imem_we), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_wc", 32'(word_count), 0);
    chk("rst_addr", imem_addr, 0);
    reset = 1'b0;
    tick();
    chk("idle_in_ready", 32'(in_ready), 0);

    // Basic encoding of all three legal formats.
    begin_session(32'h10);
    chk("run_in_ready", 32'(in_ready), 1);
    send("t1a", 4'hE, 2'b00, 6'b101000, 4'h1, 4'h2, 24'h000005, 1'b0);
    chk("t1a_we", 32'(imem_we), 1);
    chk("t1a_addr", imem_addr, 32'h10);
    chk("t1a_wdata", imem_wdata, 32'hE2812005);
    send("t1b", 4'hE, 2'b01, 6'b011001, 4'h0, 4'h3, 24'h000004, 1'b0);
    chk("t1b_addr", imem_addr, 32'h14);
    chk("t1b_wdata", imem_wdata, 32'hE5903004);
    send("t1c", 4'hE, 2'b10, 6'b110000, 4'h0, 4'h0, 24'h000FFE, 1'b1);
    chk("t1c_we", 32'(imem_we), 1);
    chk("t1c_addr", imem_addr, 32'h18);
    chk("t1c_wdata", imem_wdata, 32'hEB000FFE);
    chk("t1_drain_in_ready", 32'(in_ready), 0);
    tick();
    chk("t1_empty_we", 32'(imem_we), 0);
    chk("t1_early_done", 32'(done), 0);
    tick();
    chk("t1_done", 32'(done), 1);
    chk("t1_wc", 32'(word_count), 3);
    tick();
    chk("t1_done_pulse", 32'(done), 0);
    chk("t1_wc_hold", 32'(word_count), 3);

    // Back-pressure: memory busy while five bundles are offered.
    begin_session(32'h100);
    imem_busy = 1'b1;
    k = 0;
    set_fields(4'hE, 2'b00, 6'h00, 4'h0, 4'h0, 24'h1, 1'b0);
    in_valid = 1'b1;
    #1;
    for (int c = 0; c < 8; c++) begin
      chk("t3_busy_we", 32'(imem_we), 0);
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        k++;
        set_fields(4'hE, 2'b00, 6'h00, 4'h0, 4'(k), 24'(k + 1), (k == 4));
      end
    end
    chk("t3_accepts", 32'(k), 4);
    chk("t3_full_in_ready", 32'(in_ready), 0);
    imem_busy = 1'b0;
    #1;
    for (int j = 0; j < 5; j++) begin
      chk("t3_we", 32'(imem_we), 1);
      chk("t3_addr", imem_addr, 32'h100 + 32'(4 * j));
      chk("t3_wdata", imem_wdata, exp_busy[j]);
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        k++;
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
    end
    chk("t3_total_accepts", 32'(k), 5);
    chk("t3_after_we", 32'(imem_we), 0);
    tick();
    chk("t3_done", 32'(done), 1);
    chk("t3_wc", 32'(word_count), 5);
    tick();

    // Illegal bundles are dropped and flagged.
    begin_session(32'h200);
    send("t4a", 4'hE, 2'b11, 6'h00, 4'h0, 4'h0, 24'h000000, 1'b0);
    chk("t4a_err", 32'(err), 1);
    chk("t4a_we", 32'(imem_we), 0);
    send("t4b", 4'hE, 2'b00, 6'h00, 4'h0, 4'h1, 24'h001005, 1'b0);
    chk("t4b_err", 32'(err), 1);
    chk("t4b_we", 32'(imem_we), 0);
    send("t4c", 4'hE, 2'b00, 6'h00, 4'h0, 4'h1, 24'h000005, 1'b1);
    chk("t4c_err", 32'(err), 0);
    chk("t4c_we", 32'(imem_we), 1);
    chk("t4c_addr", imem_addr, 32'h200);
    chk("t4c_wdata", imem_wdata, 32'hE0001005);
    tick(); tick();
    chk("t4_done", 32'(done), 1);
    chk("t4_wc", 32'(word_count), 1);
    tick();

    // Session made only of an illegal last bundle.
    begin_session(32'h280);
    send("t4d", 4'hE, 2'b11, 6'h00, 4'h0, 4'h0, 24'h0, 1'b1);
    chk("t4d_err", 32'(err), 1);
    chk("t4d_we", 32'(imem_we), 0);
    tick();
    chk("t4d_done", 32'(done), 1);
    chk("t4d_wc", 32'(word_count), 0);
    tick();

    // Address wrap on the 8-bit instance.
    begin_session(32'hFC);
    send("t5a", 4'hE, 2'b00, 6'h00, 4'h0, 4'h0, 24'h000001, 1'b0);
    chk("t5a_addr8", 32'(imem_addr8), 32'hFC);
    chk("t5a_we8", 32'(imem_we8), 1);
    send("t5b", 4'hE, 2'b00, 6'h00, 4'h0, 4'h0, 24'h000002, 1'b1);
    chk("t5b_addr8", 32'(imem_addr8), 32'h00);
    chk("t5b_wdata8", imem_wdata8, 32'hE0000002);
    chk("t5b_addr32", imem_addr, 32'h100);
    tick(); tick();
    chk("t5_done8", 32'(done8), 1);
    tick();

    // Reset while draining with three words buffered.
    begin_session(32'h300);
    imem_busy = 1'b1;
    send("t6a", 4'hE, 2'b00, 6'h00, 4'h0, 4'h1, 24'h1, 1'b0);
    send("t6b", 4'hE, 2'b00, 6'h00, 4'h0, 4'h2, 24'h2, 1'b0);
    send("t6c", 4'hE, 2'b00, 6'h00, 4'h0, 4'h3, 24'h3, 1'b1);
    chk("t6_drain_in_ready", 32'(in_ready), 0);
    reset = 1'b1;
    imem_busy = 1'b0;
    tick();
    reset = 1'b0;
    chk("t6_rst_we", 32'(imem_we), 0);
    chk("t6_rst_in_ready", 32'(in_ready), 0);
    chk("t6_rst_done", 32'(done), 0);
    chk("t6_rst_wc", 32'(word_count), 0);
    begin_session(32'h40);
    send("t6d", 4'hE, 2'b00, 6'h00, 4'h0, 4'h2, 24'h000007, 1'b1);
    chk("t6d_addr", imem_addr, 32'h40);
    chk("t6d_wdata", imem_wdata, 32'hE0002007);
    tick(); tick();
    chk("t6_done", 32'(done), 1);
    chk("t6_wc", 32'(word_count), 1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_mem_encoder.md
Name: instr_mem_encoder

Overview:
- Producer side of the instruction-word format consumed by the CPU's decoder.
- Accepts instruction fields (cond, op, funct, rn, rd, operand) over a valid/ready stream and packs each into a 32-bit instruction word.
- Buffers the words in a small FIFO and writes them sequentially into instruction memory from a programmable start address.
- Used by the boot/test-loader path to place programs in instruction memory before the pipeline is released.

Parameters:
DEPTH, 4, encoded-word FIFO depth in entries (power of 2, >=2)
ADDR_W, 32, instruction memory byte-address width

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous active-high reset
start  input  1  one-cycle pulse; begins a load session, sampled only in IDLE
start_addr  input  ADDR_W  byte address of first word, captured on start
in_valid  input  1  field bundle valid
in_ready  output  1  encoder can accept a bundle this cycle
in_last  input  1  bundle is the final one of the session
in_cond  input  4  condition field
in_op  input  2  op field
in_funct  input  6  funct field
in_rn  input  4  Rn field
in_rd  input  4  Rd field
in_operand  input  24  Src2 (low 12 bits) or branch imm24
imem_busy  input  1  memory cannot take a write this cycle
imem_we  output  1  write strobe
imem_addr  output  ADDR_W  write byte address
imem_wdata  output  32  encoded instruction word
err  output  1  one-cycle pulse: accepted bundle was illegal and was dropped
done  output  1  one-cycle pulse: session complete, all words written
word_count  output  16  words written in current/last session

Behaviour:
- Clock/reset: single clock; reset is synchronous and active-high.
- Reset: state IDLE, FIFO empty, address and word_count = 0; in_ready, imem_we, err, done = 0. Reset mid-session discards buffered words; no partial write follows reset.
- Handshake: transfer when in_valid && in_ready.
  - in_ready = (state==RUN) && !fifo_full.
  - No push into a full FIFO even if a pop occurs the same cycle.
- Encoding:
  - op 00/01: word = {cond, op, funct, rn, rd, operand[11:0]}.
  - op 10: word = {cond, 2'b10, funct[5:4], operand[23:0]}.
- Illegal bundles: op==11, or op 00/01 with operand[23:12]!=0.
  - Accepted (handshake completes); not pushed.
  - err high the cycle after acceptance.
  - Address and word_count unaffected.
- Latency: a legal bundle accepted at edge N is in the FIFO at N. With FIFO previously empty and imem_busy=0, imem_we is high in cycle N..N+1 (write at edge N+1).
- Write side:
  - When FIFO non-empty and !imem_busy: imem_we=1, head word on imem_wdata at imem_addr, popped at the edge.
  - At the same edge: imem_addr += 4 (wraps modulo 2^ADDR_W), word_count += 1.
  - imem_we=0 whenever imem_busy=1. wdata/addr hold while a word is stalled.
  - Words are written strictly in acceptance order.
- FSM:
  - IDLE: on start, capture start_addr, clear word_count and FIFO -> RUN.
  - RUN: accept bundles; on accepted in_last (legal or illegal) -> DRAIN.
  - DRAIN: in_ready=0; when FIFO empty and no write pending -> DONE.
  - DONE: done=1 for one cycle -> IDLE. word_count holds until next start.
- start outside IDLE is ignored.
- in_last on the very first bundle is legal: single-word session.
- All-illegal session: zero writes; done still pulses; word_count=0.

Test Plan:
1. start_addr=0x10; bundle cond=E, op=00, funct=101000, rn=1, rd=2, operand=0x000005 -> imem_we with addr 0x10, wdata 0xE2812005 one cycle after accept.
2. Next: op=01, funct=011001, rn=0, rd=3, operand=0x4, cond=E -> addr 0x14, wdata 0xE5903004. Then op=10, funct=110000, operand=0x000FFE, in_last=1 -> addr 0x18, wdata 0xEB000FFE; done one cycle after FIFO empties; word_count=3.
3. imem_busy=1 for 8 cycles while offering 5 legal bundles (DEPTH=4):
   - in_ready drops after 4 accepts; imem_we stays 0 while busy.
   - After release: 5 words written in order to consecutive addresses, no gaps.
4. Illegal input: op=11 bundle, then op=00 with operand=0x001005 -> err pulse for each; no imem_we; next legal word lands at the unadvanced address.
5. Wrap: ADDR_W=8, start_addr=0xFC, 2 words -> addresses 0xFC then 0x00.
6. Reset asserted in DRAIN with 3 words buffered:
   - Next cycle: imem_we=0, in_ready=0, done=0.
   - New start at 0x40 writes first word to 0x40; word_count restarts from 0.
